int_sequencer: RTL and testbench
================================

INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-003 interruptSignal  in  2  external interrupt lines; bit 0 has the highest priority.
REQ-004 instrBoundary  in  1  pipeline drained; an interrupt or return may start this cycle.
REQ-005 rti  in  1  return-from-interrupt instruction at boundary; valid only with instrBoundary=1.
REQ-006 pc  in  32  current PC to save.
REQ-007 ccr  in  4  current flags {OF,CF,NF,ZF} to save.
REQ-008 sp  in  16  current stack pointer.
REQ-009 memData  in  16  data-memory read data; valid in the same cycle as MR.
REQ-010 stall  out  1  freeze fetch/PC; high in every non-IDLE state.
REQ-011 MR, MW  out  1 each  data-memory read/write strobes; never both high.
REQ-012 memAddr  out  16  data-memory address.
REQ-013 memWData  out  16  data-memory write data.
REQ-014 pcLoad  out  1  one-cycle pulse; the PC takes pcNew.
REQ-015 pcNew  out  32  PC load value.
REQ-016 ccrLoad, ccrNew  out  1, 4  one-cycle flag restore.
REQ-017 spWrite, spNew  out  1, 16  one-cycle stack pointer update.
REQ-018 inService  out  1  high from interrupt entry until RTI completes; blocks nesting.

Function
REQ-019 Each line SHALL be rising-edge detected against a prev register and latched into pending[1:0]; the bit stays set until its service begins.
REQ-020 States SHALL be IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, VEC_HI, VEC_LO, ENTER, POP_CCR, POP_LO, POP_HI, EXIT.
REQ-021 In IDLE with instrBoundary=1 and rti=1, the block SHALL go to POP_CCR; rti has priority over pending interrupts.
REQ-022 In IDLE with instrBoundary=1, rti=0, inService=0 and pending!=0, the block SHALL go to PUSH_HI.
- Snapshot pc, ccr and sp into internal registers.
- Select the lowest pending index; clear only that bit.
REQ-023 Entry SHALL take six cycles, one state each:
- PUSH_HI: MW, addr=sp, data=pc[31:16].
- PUSH_LO: MW, addr=sp-1, data=pc[15:0].
- PUSH_CCR: MW, addr=sp-2, data={12'b0,ccr}.
- VEC_HI: MR, addr=2+2*idx; capture memData into pcNew[31:16].
- VEC_LO: MR, addr=3+2*idx; capture memData into pcNew[15:0].
- ENTER: pcLoad=1, spWrite=1, spNew=sp-3; set inService; next state IDLE.
REQ-024 Return SHALL take four cycles:
- POP_CCR: MR, addr=sp+1; capture ccr.
- POP_LO: MR, addr=sp+2; capture pc[15:0].
- POP_HI: MR, addr=sp+3; capture pc[31:16].
- EXIT: pcLoad=1, ccrLoad=1, spWrite=1, spNew=sp+3; clear inService; next state IDLE.
REQ-025 All stack address arithmetic SHALL be modulo 2^16 (e.g. sp=0x0001 with -3 gives 0xFFFE).
REQ-026 Edges arriving in any state SHALL still latch into pending; an edge on an already-pending line is absorbed (no count).
REQ-027 Memory data and address outputs SHALL be 0 whenever MR=MW=0; every pulse output is low outside its state.
REQ-028 Out of IDLE, instrBoundary, rti and sp changes SHALL be ignored; the snapshots are used throughout the sequence.
REQ-029 Pending lines SHALL wait while inService=1 and are serviced at the first boundary after EXIT.

Reset
REQ-030 With reset=0 at an edge, the block SHALL load:
- state=IDLE;
- pending, prev, inService and snapshot registers all 0;
- all outputs 0 from the next cycle, including mid-sequence; no partial pcLoad or spWrite is emitted.
REQ-031 A line held high through reset SHALL register as one new edge after release.

Verification
REQ-032 Setup sp=0x0100, pc=0x00001234, ccr=0x5, memory[2..3]=0x0000,0x0400; pulse line 0 with boundary=1. Required response:
- writes 0x0000@0x0100, 0x1234@0x00FF, 0x0005@0x00FE;
- then pcNew=0x00000400, spNew=0x00FD in cycle 6.
REQ-033 Both lines rise in the same cycle: line 0 is serviced first. Line 1 is serviced only after an RTI, using vector words 4..5.
REQ-034 RTI with sp=0x00FD after REQ-032: reads 0x00FE, 0x00FF, 0x0100; then EXIT drives pcNew=0x00001234, ccrNew=0x5, spNew=0x0100.
REQ-035 sp=0x0001, interrupt entry: write addresses 0x0001, 0x0000, 0xFFFF; spNew=0xFFFE.
REQ-036 reset=0 during PUSH_LO: the next cycle shows stall=0, MW=0 and pending=0, with no pcLoad afterwards.
REQ-037 rti and a pending interrupt together at a boundary: the POP sequence runs first, then the interrupt enters at the next boundary.

Source files
------------

// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - interrupt entry/return sequencer with stack push/pop and vector fetch
//
// Detects rising edges on two interrupt lines and, at an instruction boundary,
// saves PC and flags to the data stack, fetches a 32-bit vector, and loads the PC.
// An RTI at a boundary pops flags and PC back and restores the stack pointer.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   interruptSignal[1:0] interrupt lines, bit 0 has the highest priority
//   instrBoundary, rti  pipeline drained / return-from-interrupt at that boundary
//   pc, ccr, sp         processor state captured when a sequence starts
//   memData             data-memory read data, valid in the cycle MR is high
//   stall               high in every non-IDLE state
//   MR, MW, memAddr, memWData  data-memory strobes, address and write data
//   pcLoad/pcNew, ccrLoad/ccrNew, spWrite/spNew  one-cycle state update pulses
//   inService           high from interrupt entry until RTI completes
module int_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  interruptSignal,
  input  logic        instrBoundary,
  input  logic        rti,
  input  logic [31:0] pc,
  input  logic [3:0]  ccr,
  input  logic [15:0] sp,
  input  logic [15:0] memData,
  output logic        stall,
  output logic        MR,
  output logic        MW,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  output logic        pcLoad,
  output logic [31:0] pcNew,
  output logic        ccrLoad,
  output logic [3:0]  ccrNew,
  output logic        spWrite,
  output logic [15:0] spNew,
  output logic        inService
);

  typedef enum logic [3:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, VEC_HI, VEC_LO, ENTER,
    POP_CCR, POP_LO, POP_HI, EXIT
  } state_t;

  state_t      state;
  logic [1:0]  prev;
  logic [1:0]  pending;
  logic [1:0]  rise;
  logic [1:0]  selMask;
  logic        vecIdx;
  logic [15:0] snapPcLo;   // high half is pushed straight from the pc input
  logic [3:0]  snapCcr;
  logic [15:0] snapSp;
  logic [31:0] dataBuf;    // vector high word on entry, popped PC low word on return
  logic [3:0]  ccrBuf;

  always_comb begin
    rise    = interruptSignal & ~prev;
    selMask = pending[0] ? 2'b01 : 2'b10;
  end

  // Outputs are registered for the state being entered, so each output is
  // visible exactly during the cycle its state is current.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      prev      <= 2'b00;
      pending   <= 2'b00;
      inService <= 1'b0;
      vecIdx    <= 1'b0;
      snapPcLo  <= 16'h0;
      snapCcr   <= 4'h0;
      snapSp    <= 16'h0;
      dataBuf   <= 32'h0;
      ccrBuf    <= 4'h0;
      stall     <= 1'b0;
      MR        <= 1'b0;
      MW        <= 1'b0;
      memAddr   <= 16'h0;
      memWData  <= 16'h0;
      pcLoad    <= 1'b0;
      pcNew     <= 32'h0;
      ccrLoad   <= 1'b0;
      ccrNew    <= 4'h0;
      spWrite   <= 1'b0;
      spNew     <= 16'h0;
    end else begin
      prev     <= interruptSignal;
      pending  <= pending | rise;
      stall    <= 1'b1;
      MR       <= 1'b0;
      MW       <= 1'b0;
      memAddr  <= 16'h0;
      memWData <= 16'h0;
      pcLoad   <= 1'b0;
      pcNew    <= 32'h0;
      ccrLoad  <= 1'b0;
      ccrNew   <= 4'h0;
      spWrite  <= 1'b0;
      spNew    <= 16'h0;

      case (state)
        IDLE: begin
          if (instrBoundary && rti) begin
            state   <= POP_CCR;
            snapSp  <= sp;
            MR      <= 1'b1;
            memAddr <= sp + 16'd1;
          end else if (instrBoundary && !inService && (pending != 2'b00)) begin
            state    <= PUSH_HI;
            snapPcLo <= pc[15:0];
            snapCcr  <= ccr;
            snapSp   <= sp;
            vecIdx   <= ~pending[0];
            // A fresh edge on the line being serviced re-arms it.
            pending  <= (pending & ~selMask) | rise;
            MW       <= 1'b1;
            memAddr  <= sp;
            memWData <= pc[31:16];
          end else begin
            stall <= 1'b0;
          end
        end
        PUSH_HI: begin
          state    <= PUSH_LO;
          MW       <= 1'b1;
          memAddr  <= snapSp - 16'd1;
          memWData <= snapPcLo;
        end
        PUSH_LO: begin
          state    <= PUSH_CCR;
          MW       <= 1'b1;
          memAddr  <= snapSp - 16'd2;
          memWData <= {12'h000, snapCcr};
        end
        PUSH_CCR: begin
          state   <= VEC_HI;
          MR      <= 1'b1;
          memAddr <= vecIdx ? 16'd4 : 16'd2;
        end
        VEC_HI: begin
          state          <= VEC_LO;
          dataBuf[31:16] <= memData;
          MR             <= 1'b1;
          memAddr        <= vecIdx ? 16'd5 : 16'd3;
        end
        VEC_LO: begin
          state     <= ENTER;
          pcLoad    <= 1'b1;
          pcNew     <= {dataBuf[31:16], memData};
          spWrite   <= 1'b1;
          spNew     <= snapSp - 16'd3;
          inService <= 1'b1;
        end
        POP_CCR: begin
          state   <= POP_LO;
          ccrBuf  <= memData[3:0];
          MR      <= 1'b1;
          memAddr <= snapSp + 16'd2;
        end
        POP_LO: begin
          state         <= POP_HI;
          dataBuf[15:0] <= memData;
          MR            <= 1'b1;
          memAddr       <= snapSp + 16'd3;
        end
        POP_HI: begin
          state     <= EXIT;
          pcLoad    <= 1'b1;
          pcNew     <= {memData, dataBuf[15:0]};
          ccrLoad   <= 1'b1;
          ccrNew    <= ccrBuf;
          spWrite   <= 1'b1;
          spNew     <= snapSp + 16'd3;
          inService <= 1'b0;
        end
        ENTER, EXIT: begin
          state <= IDLE;
          stall <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - self-checking bench for int_sequencer
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  interruptSignal;
  logic        instrBoundary;
  logic        rti;
  logic [31:0] pc;
  logic [3:0]  ccr;
  logic [15:0] sp;
  logic [15:0] memData;
  logic        stall, MR, MW, pcLoad, ccrLoad, spWrite, inService;
  logic [15:0] memAddr, memWData, spNew;
  logic [31:0] pcNew;
  logic [3:0]  ccrNew;

  always #5 clk = ~clk;

  int_sequencer dut (
    .clk(clk), .reset(reset), .interruptSignal(interruptSignal),
    .instrBoundary(instrBoundary), .rti(rti), .pc(pc), .ccr(ccr), .sp(sp),
    .memData(memData), .stall(stall), .MR(MR), .MW(MW), .memAddr(memAddr),
    .memWData(memWData), .pcLoad(pcLoad), .pcNew(pcNew), .ccrLoad(ccrLoad),
    .ccrNew(ccrNew), .spWrite(spWrite), .spNew(spNew), .inService(inService)
  );

  logic [15:0] mem [0:65535];
  assign memData = MR ? mem[memAddr] : 16'h0000;

  int errors = 0;
  int checks = 0;

  // Processor state as seen by the bench: updated only through the load pulses.
  logic [31:0] cpuPc;
  logic [3:0]  cpuCcr;
  logic [15:0] cpuSp;
  logic [15:0] wrA[$];
  logic [15:0] wrD[$];
  logic [15:0] rdA[$];
  int          loads, ccrLoads;
  bit          bothSeen = 0;
  bit          quietBad = 0;

  typedef struct {
    string       name;
    logic [15:0] sp;
    logic [31:0] pc;
    logic [3:0]  ccr;
    logic [1:0]  lines;
    logic [15:0] a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [15:0] rd0;
    logic [31:0] expPc;
    logic [15:0] expSp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (MR && MW) bothSeen = 1;
    if (!MR && !MW && (memAddr != 16'h0 || memWData != 16'h0)) quietBad = 1;
    if (MW) begin
      mem[memAddr] = memWData;
      wrA.push_back(memAddr);
      wrD.push_back(memWData);
    end
    if (MR) rdA.push_back(memAddr);
    if (pcLoad) begin loads++; cpuPc = pcNew; end
    if (ccrLoad) begin ccrLoads++; cpuCcr = ccrNew; end
    if (spWrite) cpuSp = spNew;
  endtask

  task automatic pulseLines(input logic [1:0] mask);
    interruptSignal = mask;
    step();
    interruptSignal = 2'b00;
    step();
  endtask

  task automatic runSeq(input bit doRti, input bit noisy, output int cyc);
    wrA.delete(); wrD.delete(); rdA.delete();
    loads = 0; ccrLoads = 0;
    pc = cpuPc; ccr = cpuCcr; sp = cpuSp;
    rti = doRti; instrBoundary = 1'b1;
    step();
    cyc = 0;
    while (stall === 1'b1 && cyc < 20) begin
      cyc++;
      if (noisy) begin
        instrBoundary = 1'($urandom);
        rti = 1'($urandom);
        sp = 16'($urandom);
        pc = $urandom;
        ccr = 4'($urandom);
      end
      step();
    end
    instrBoundary = 1'b0; rti = 1'b0;
    pc = cpuPc; ccr = cpuCcr; sp = cpuSp;
  endtask

  task automatic doEntry(input string name, input logic [15:0] a0, a1, a2,
                         input logic [15:0] d0, d1, d2, input logic [15:0] rd0,
                         input logic [31:0] expPc, input logic [15:0] expSp, input bit noisy);
    int cyc;
    runSeq(1'b0, noisy, cyc);
    chk({name, "_cycles"}, cyc, 6);
    chk({name, "_nwr_nrd"}, {wrA.size(), rdA.size()}, {32'd3, 32'd2});
    if (wrA.size() == 3)
      chk({name, "_writes"}, {wrA[0], wrD[0], wrA[1], wrD[1], wrA[2], wrD[2]},
          {a0, d0, a1, d1, a2, d2});
    if (rdA.size() == 2)
      chk({name, "_vec_reads"}, {rdA[0], rdA[1]}, {rd0, rd0 + 16'd1});
    chk({name, "_pcNew"}, {loads, cpuPc}, {32'd1, expPc});
    chk({name, "_spNew_inService"}, {cpuSp, inService}, {expSp, 1'b1});
  endtask

  task automatic doReturn(input string name, input logic [15:0] r0,
                          input logic [31:0] expPc, input logic [3:0] expCcr,
                          input logic [15:0] expSp, input bit noisy);
    int cyc;
    runSeq(1'b1, noisy, cyc);
    chk({name, "_cycles"}, cyc, 4);
    chk({name, "_nwr_nrd"}, {wrA.size(), rdA.size()}, {32'd0, 32'd3});
    if (rdA.size() == 3)
      chk({name, "_pop_reads"}, {rdA[0], rdA[1], rdA[2]}, {r0, r0 + 16'd1, r0 + 16'd2});
    chk({name, "_restore"}, {loads, ccrLoads, cpuPc, cpuCcr, cpuSp, inService},
        {32'd1, 32'd1, expPc, expCcr, expSp, 1'b0});
  endtask

  task automatic expectIdle(input string name, input int n);
    bit saw;
    saw = 0; loads = 0;
    instrBoundary = 1'b1; rti = 1'b0;
    repeat (n) begin
      step();
      if (stall) saw = 1;
    end
    instrBoundary = 1'b0;
    chk(name, {saw, loads}, 0);
  endtask

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  pend, extra;
    logic [15:0] s0;
    logic [31:0] p0, vec;
    logic [3:0]  c0;
    int          idx;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[2] = 16'h0000; mem[3] = 16'h0400;
    mem[4] = 16'h0012; mem[5] = 16'h3456;

    tbl[0] = '{"req032", 16'h0100, 32'h0000_1234, 4'h5, 2'b01,
               16'h0100, 16'h00FF, 16'h00FE, 16'h0000, 16'h1234, 16'h0005,
               16'h0002, 32'h0000_0400, 16'h00FD};
    tbl[1] = '{"wrap_sp1", 16'h0001, 32'h89AB_CDEF, 4'hA, 2'b01,
               16'h0001, 16'h0000, 16'hFFFF, 16'h89AB, 16'hCDEF, 16'h000A,
               16'h0002, 32'h0000_0400, 16'hFFFE};
    tbl[2] = '{"line1", 16'h2000, 32'h0000_BEEF, 4'hF, 2'b10,
               16'h2000, 16'h1FFF, 16'h1FFE, 16'h0000, 16'hBEEF, 16'h000F,
               16'h0004, 32'h0012_3456, 16'h1FFD};
    tbl[3] = '{"wrap_sp0", 16'h0000, 32'hFFFF_0000, 4'h0, 2'b10,
               16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000,
               16'h0004, 32'h0012_3456, 16'hFFFD};

    reset = 1'b0; interruptSignal = 2'b00; instrBoundary = 1'b0; rti = 1'b0;
    pc = 32'h0; ccr = 4'h0; sp = 16'h0;
    cpuPc = 32'h0; cpuCcr = 4'h0; cpuSp = 16'h0;
    repeat (3) step();
    chk("reset_outputs", {stall, MR, MW, memAddr, memWData, pcLoad, pcNew, ccrLoad,
                          ccrNew, spWrite, spNew, inService}, 0);
    reset = 1'b1;
    expectIdle("reset_no_pending", 4);

    for (int i = 0; i < 4; i++) begin
      cpuSp = tbl[i].sp; cpuPc = tbl[i].pc; cpuCcr = tbl[i].ccr;
      pulseLines(tbl[i].lines);
      doEntry(tbl[i].name, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1,
              tbl[i].d2, tbl[i].rd0, tbl[i].expPc, tbl[i].expSp, 1'b0);
      doReturn({tbl[i].name, "_rti"}, tbl[i].expSp + 16'd1, tbl[i].pc, tbl[i].ccr,
               tbl[i].sp, 1'b0);
    end

    // Both lines in one cycle: line 0 first, line 1 only after RTI.
    cpuSp = 16'h0400; cpuPc = 32'h0000_1000; cpuCcr = 4'h9;
    pulseLines(2'b11);
    doEntry("both_l0", 16'h0400, 16'h03FF, 16'h03FE, 16'h0000, 16'h1000, 16'h0009,
            16'h0002, 32'h0000_0400, 16'h03FD, 1'b0);
    expectIdle("both_blocked", 5);
    doReturn("both_ret0", 16'h03FE, 32'h0000_1000, 4'h9, 16'h0400, 1'b0);
    doEntry("both_l1", 16'h0400, 16'h03FF, 16'h03FE, 16'h0000, 16'h1000, 16'h0009,
            16'h0004, 32'h0012_3456, 16'h03FD, 1'b0);
    doReturn("both_ret1", 16'h03FE, 32'h0000_1000, 4'h9, 16'h0400, 1'b0);
    expectIdle("both_done", 3);

    // Edges while in service wait; a repeated edge is absorbed.
    cpuSp = 16'h0800; cpuPc = 32'h0ABC_DEF0; cpuCcr = 4'h2;
    pulseLines(2'b01);
    doEntry("svc_l0", 16'h0800, 16'h07FF, 16'h07FE, 16'h0ABC, 16'hDEF0, 16'h0002,
            16'h0002, 32'h0000_0400, 16'h07FD, 1'b0);
    pulseLines(2'b10);
    pulseLines(2'b10);
    doReturn("svc_ret0", 16'h07FE, 32'h0ABC_DEF0, 4'h2, 16'h0800, 1'b0);
    doEntry("svc_l1", 16'h0800, 16'h07FF, 16'h07FE, 16'h0ABC, 16'hDEF0, 16'h0002,
            16'h0004, 32'h0012_3456, 16'h07FD, 1'b0);
    doReturn("svc_ret1", 16'h07FE, 32'h0ABC_DEF0, 4'h2, 16'h0800, 1'b0);
    expectIdle("svc_absorbed", 3);

    // RTI and a pending interrupt together: the return runs first.
    cpuSp = 16'h3000; cpuPc = 32'h0000_7777; cpuCcr = 4'hC;
    mem[16'h3001] = 16'h0003; mem[16'h3002] = 16'h5678; mem[16'h3003] = 16'h0009;
    pulseLines(2'b01);
    doReturn("rti_first", 16'h3001, 32'h0009_5678, 4'h3, 16'h3003, 1'b0);
    doEntry("rti_then_irq", 16'h3003, 16'h3002, 16'h3001, 16'h0009, 16'h5678, 16'h0003,
            16'h0002, 32'h0000_0400, 16'h3000, 1'b0);
    doReturn("rti_then_ret", 16'h3001, 32'h0009_5678, 4'h3, 16'h3003, 1'b0);

    // Reset while in PUSH_LO abandons the sequence and the pending request.
    cpuSp = 16'h0100; cpuPc = 32'h0000_1234; cpuCcr = 4'h5;
    pulseLines(2'b01);
    pc = cpuPc; ccr = cpuCcr; sp = cpuSp; instrBoundary = 1'b1; loads = 0;
    step();
    step();
    chk("rst_mid_in_push_lo", {MW, memAddr, memWData}, {1'b1, 16'h00FF, 16'h1234});
    reset = 1'b0;
    step();
    chk("rst_mid_outputs", {stall, MW, MR, pcLoad, spWrite, inService, loads}, 0);
    reset = 1'b1;
    expectIdle("rst_mid_no_resume", 10);

    // A line held high through reset counts as exactly one edge.
    interruptSignal = 2'b10; reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step();
    cpuSp = 16'h0200; cpuPc = 32'h0000_4321; cpuCcr = 4'h1;
    doEntry("held_l1", 16'h0200, 16'h01FF, 16'h01FE, 16'h0000, 16'h4321, 16'h0001,
            16'h0004, 32'h0012_3456, 16'h01FD, 1'b0);
    doReturn("held_ret", 16'h01FE, 32'h0000_4321, 4'h1, 16'h0200, 1'b0);
    expectIdle("held_once", 4);
    interruptSignal = 2'b00;
    step();

    // Random: a model of pending requests and a stack of saved contexts,
    // with input noise on sp/pc/ccr/rti/boundary during every sequence.
    for (int it = 0; it < 25; it++) begin
      for (int k = 2; k < 6; k++) mem[k] = 16'($urandom);
      cpuSp = 16'($urandom_range(8, 65535));
      cpuPc = $urandom;
      cpuCcr = 4'($urandom);
      pend = 2'($urandom_range(1, 3));
      pulseLines(pend);
      if ($urandom_range(0, 1) == 1) pulseLines(pend);
      while (pend != 2'b00) begin
        idx = pend[0] ? 0 : 1;
        pend[idx] = 1'b0;
        vec = {mem[2 + 2 * idx], mem[3 + 2 * idx]};
        s0 = cpuSp; p0 = cpuPc; c0 = cpuCcr;
        doEntry($sformatf("rnd%0d_entry", it), s0, s0 - 16'd1, s0 - 16'd2, p0[31:16],
                p0[15:0], {12'h000, c0}, 16'(2 + 2 * idx), vec, s0 - 16'd3, 1'b1);
        if ($urandom_range(0, 2) == 0) begin
          extra = 2'($urandom_range(1, 3));
          pulseLines(extra);
          pend = pend | extra;
        end
        doReturn($sformatf("rnd%0d_return", it), s0 - 16'd2, p0, c0, s0, 1'b1);
      end
      expectIdle($sformatf("rnd%0d_idle", it), 2);
    end

    chk("mr_mw_exclusive", bothSeen, 0);
    chk("quiet_bus_zero", quietBad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
